sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in/parallel-out deserializer that sits directly downstream of the enabled D flip-flop stage. It collects the flop's registered serial bit stream (`d`, qualified by `en`) into WIDTH-bit words. Each completed word is presented on a one-entry output register with a valid/ready handshake. Words that arrive while the output register is still occupied are dropped, and the drop is reported on a sticky overrun flag.

## Interface
- `WIDTH`, 8: word width in bits; legal range is 2 or more.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `q_par[WIDTH-1]`; 0 means it lands in `q_par[0]`.
- `CW`, `$clog2(WIDTH)`: width of the bit counter. Derived; do not override.
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it (low) immediately forces every register to its reset value, regardless of `clk`.
- `d`  in  1: serial data bit, sampled only when `en`=1.
- `en`  in  1: bit-valid qualifier. When 0, the shift register and counter hold.
- `clr`  in  1: synchronous flush of the partial word and the overrun flag.
- `q_ready`  in  1: the consumer accepts the current word.
- `q_par`  out  WIDTH: assembled word.
- `q_valid`  out  1: `q_par` holds a word not yet accepted.
- `overrun`  out  1: sticky; at least one completed word was dropped.
- `bit_cnt`  out  CW: number of bits collected so far in the current word, 0..WIDTH-1.

## Operation
- Reset (`rst`=0): `sr`=0, `bit_cnt`=0, `q_par`=0, `q_valid`=0, `overrun`=0.
- Shift on `en`=1 (with `clr`=0):
  - MSB_FIRST=1: `sr` <= {`sr`[WIDTH-2:0], `d`}.
  - MSB_FIRST=0: `sr` <= {`d`, `sr`[WIDTH-1:1]}.
  - `bit_cnt` increments.
- Word completion: occurs when `en`=1 and `bit_cnt`==WIDTH-1.
  - The next value of `sr` (which includes the current `d`) is the completed word.
  - `bit_cnt` wraps to 0.
  - `sr` is not cleared; the next word simply shifts over it.
- The output register is a two-state FSM:
  - EMPTY (`q_valid`=0) to FULL on word completion: `q_par` <= completed word.
  - FULL with `q_ready`=1 and no completion: accept, go to EMPTY. `q_par` holds its last value.
  - FULL with `q_ready`=1 and completion in the same cycle: accept the old word and load the new one. Stay FULL; `q_valid` stays 1 with no bubble.
  - FULL with `q_ready`=0 and completion: the new word is dropped. `overrun` <= 1, `q_par` unchanged, state stays FULL.
  - FULL with `q_ready`=0 and no completion: hold. `q_par` stays stable.
- `q_ready` is ignored while EMPTY.
- `clr`=1:
  - Effects: `sr`<=0, `bit_cnt`<=0, `overrun`<=0.
  - `clr` takes priority over `en`; the bit presented in that cycle is discarded and cannot complete a word.
  - `clr` does not touch `q_par`, `q_valid` or the handshake; an accept in the same cycle still happens.
- Arithmetic: `bit_cnt` counts modulo WIDTH, with an explicit compare against WIDTH-1. It must never reach WIDTH, including for non-power-of-2 WIDTH.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency: `q_valid` rises on the same clock edge that samples the WIDTH-th `en`=1 bit. It is visible in the following cycle.
- Throughput: one word per WIDTH `en` cycles, sustained when `q_ready`=1. Back-to-back `en`=1 streams never overrun while `q_ready` is held at 1.
- Handshake: a transfer occurs at a rising edge where `q_valid`=1 and `q_ready`=1. `q_valid` and `q_par` must not change while `q_valid`=1 and `q_ready`=0, except for reset.
- `en` gaps of any length are allowed mid-word; `bit_cnt` and `sr` hold across them.
- Reset mid-word or mid-handshake: outputs go to their reset values immediately (asynchronously). The partial word is lost. The first `en` bit after release becomes bit 0 of a new word.
- Reset release is synchronous to `clk` at the integration level. The block adds no synchronizer.

## Test plan
- Reset: shift 3 bits, then pulse `rst`=0 between clock edges. Required: `q_par`=0, `q_valid`=0, `overrun`=0 and `bit_cnt`=0 immediately. A following 8-bit word 8'h5A is received intact.
- MSB_FIRST=1, WIDTH=8, `q_ready`=1: shift 1,0,1,0,0,1,0,1 with `en`=1 every cycle. Required: `q_par`=8'hA5 and `q_valid` high for exactly one cycle, the cycle after the 8th edge. With MSB_FIRST=0 the same stream gives 8'hA5 bit-reversed, i.e. 8'hA5 rebuilt LSB-first = 8'hA5.
- `en` gaps: send 8'h3C with 2 idle `en`=0 cycles between every bit. Required: `bit_cnt` holds during gaps; `q_par`=8'h3C.
- Backpressure and overrun: `q_ready`=0, send 8'h3C then 8'hC3 back-to-back. Required:
  - `q_par` stays 8'h3C.
  - `overrun`=1 from the cycle after the 16th bit.
  - When `q_ready` is raised for 1 cycle, `q_valid` drops.
  - `overrun` stays 1 until `clr` is pulsed.
- Simultaneous accept and load: `q_valid`=1 holding 8'h11, `q_ready`=1 on the edge that completes 8'h22. Required: `q_par`=8'h22, `q_valid` stays 1, `overrun`=0.
- Flush: shift 3 bits, then pulse `clr` together with `en`=1. Required: `bit_cnt`=0 and that bit is discarded. The next 8 bits give a fresh correct word. A pending `q_valid` word is unaffected.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: packs en-qualified serial bits into WIDTH-bit
// words and presents each word on a single-entry valid/ready output register.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q_par,
    output logic             q_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q,      sr_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] q_par_q,   q_par_d;
    logic [0:0]       state_q,   state_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] sr_shift;
    logic             last_bit;
    logic             complete;

    // Shifted value including the current bit; on the last bit this is the completed word.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], d};
        end else begin
            sr_shift = {d, sr_q[WIDTH-1:1]};
        end
    end

    assign last_bit = (cnt_q == CNT_LAST);
    assign complete = en && !clr && last_bit;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            sr_d  = sr_shift;
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        q_par_d   = q_par_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d = ST_FULL;
                    q_par_d = sr_shift;
                end
            end
            ST_FULL: begin
                if (complete) begin
                    // Accept and reload in one edge keeps q_valid high with no bubble.
                    if (q_ready) begin
                        q_par_d = sr_shift;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (q_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            q_par_q   <= '0;
            state_q   <= ST_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            q_par_q   <= q_par_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign q_par   = q_par_q;
    assign q_valid = (state_q == ST_FULL);
    assign overrun = overrun_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: table-driven basic word plus hand-written
// sequences for gaps, backpressure/overrun, accept-and-load, flush and async reset.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d = 1'b0, en = 1'b0, clr = 1'b0, q_ready = 1'b0;
    logic [7:0] q_par,   q_par_l;
    logic       q_valid, q_valid_l;
    logic       overrun, overrun_l;
    logic [2:0] bit_cnt, bit_cnt_l;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr), .q_ready(q_ready),
        .q_par(q_par), .q_valid(q_valid), .overrun(overrun), .bit_cnt(bit_cnt)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr), .q_ready(q_ready),
        .q_par(q_par_l), .q_valid(q_valid_l), .overrun(overrun_l), .bit_cnt(bit_cnt_l)
    );

    typedef struct {
        logic       d, en, clr, rdy;
        logic [7:0] par;
        logic [7:0] par_lsb;
        logic       valid, ovr;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Bits go out MSB of w first; rdy_last applies on the edge that completes the word.
    task automatic send_word(input logic [7:0] w, input int gaps, input logic rdy, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            d       = w[i];
            en      = 1'b1;
            q_ready = (i == 0) ? rdy_last : rdy;
            tick();
            if (gaps > 0) begin
                en      = 1'b0;
                q_ready = rdy;
                repeat (gaps) tick();
            end
        end
        en      = 1'b0;
        q_ready = rdy;
        $display("sent word %h (gaps=%0d ready=%0b/%0b)", w, gaps, rdy, rdy_last);
    endtask

    logic [7:0] gw;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // A5 stream, MSB-first and LSB-first both yield A5; q_valid lasts one cycle.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd4};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd5};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd6};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd7};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'd0};

        tick();
        tick();
        check("reset_state", {19'd0, q_par, q_valid, overrun, bit_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            d = vecs[i].d; en = vecs[i].en; clr = vecs[i].clr; q_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_msb", i), {19'd0, q_par, q_valid, overrun, bit_cnt},
                  {19'd0, vecs[i].par, vecs[i].valid, vecs[i].ovr, vecs[i].cnt});
            check($sformatf("vec%0d_lsb", i), {19'd0, q_par_l, q_valid_l, overrun_l, bit_cnt_l},
                  {19'd0, vecs[i].par_lsb, vecs[i].valid, vecs[i].ovr, vecs[i].cnt});
        end
        en = 1'b0;
        q_ready = 1'b0;

        // en gaps: two idle cycles after every bit, counter must hold across them.
        gw = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            d = gw[7-i];
            en = 1'b1;
            tick();
            en = 1'b0;
            check($sformatf("gap_cnt_bit%0d", i), {29'd0, bit_cnt}, (i + 1) % 8);
            tick();
            tick();
            check($sformatf("gap_hold_bit%0d", i), {29'd0, bit_cnt}, (i + 1) % 8);
        end
        check("gap_word", {23'd0, q_par, q_valid}, {23'd0, 8'h3C, 1'b1});
        $display("gap word received %h", q_par);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("gap_drain", {31'd0, q_valid}, 32'd0);

        // Backpressure: second word is dropped and overrun sticks until clr.
        send_word(8'h3C, 0, 1'b0, 1'b0);
        check("bp_first", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h3C, 1'b1, 1'b0});
        send_word(8'hC3, 0, 1'b0, 1'b0);
        check("bp_overrun", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h3C, 1'b1, 1'b1});
        tick();
        tick();
        check("bp_hold", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h3C, 1'b1, 1'b1});
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("bp_accept", {30'd0, q_valid, overrun}, {30'd0, 1'b0, 1'b1});
        tick();
        check("bp_sticky", {31'd0, overrun}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("bp_clr", {31'd0, overrun}, 32'd0);

        // Accept and load on the same edge.
        send_word(8'h11, 0, 1'b0, 1'b0);
        check("al_first", {23'd0, q_par, q_valid}, {23'd0, 8'h11, 1'b1});
        send_word(8'h22, 0, 1'b0, 1'b1);
        check("al_second", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h22, 1'b1, 1'b0});
        check("al_second_lsb", {24'd0, q_par_l}, {24'd0, rev8(8'h22)});
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("al_drain", {31'd0, q_valid}, 32'd0);

        // Flush with en=1: bit discarded, pending word untouched.
        send_word(8'h11, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 1'b1; en = 1'b1;
            tick();
        end
        check("flush_pre_cnt", {29'd0, bit_cnt}, 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b0;
        check("flush_state", {20'd0, q_par, q_valid, overrun, bit_cnt}, {20'd0, 8'h11, 1'b1, 1'b0, 3'd0});
        send_word(8'h96, 0, 1'b0, 1'b1);
        check("flush_word", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h96, 1'b1, 1'b0});
        check("flush_word_lsb", {24'd0, q_par_l}, {24'd0, rev8(8'h96)});
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;

        // Asynchronous reset mid-word with a pending word and overrun set.
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 1'b1; en = 1'b1;
            tick();
        end
        en = 1'b0;
        check("rst_pre", {20'd0, q_par, q_valid, overrun, bit_cnt}, {20'd0, 8'h11, 1'b1, 1'b1, 3'd3});
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", {19'd0, q_par, q_valid, overrun, bit_cnt}, 32'd0);
        check("rst_async_lsb", {19'd0, q_par_l, q_valid_l, overrun_l, bit_cnt_l}, 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check("rst_release_cnt", {29'd0, bit_cnt}, 32'd0);
        send_word(8'h5A, 0, 1'b0, 1'b0);
        check("rst_next_word", {22'd0, q_par, q_valid, overrun}, {22'd0, 8'h5A, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
